regfile_sb: RTL

Parametrised multi-read-port integer register file with an integrated per-register busy scoreboard for the RISC-V core.
- Replaces the fixed 2-read / 32x32 register file.
- Adds a hardwired zero register, write-through bypass, pending-writeback tracking and a synchronous flush.
- Decode reads operands and busy flags. Issue marks destinations busy. Writeback writes data and clears busy.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_sb_scoreboard.sv | 48 ++++
 rtl/regfile_sb.sv | 63 ++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, register address type and zero-register helper for regfile_sb
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF = 2;
  localparam int AW_DEF = $clog2(NREGS_DEF);
  typedef logic [AW_DEF-1:0] regaddr_t;
  function automatic logic is_zero_reg(input logic [31:0] addr);
    return addr == 32'd0;
  endfunction
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// regfile_sb_scoreboard: per-register busy bits with flush > issue > writeback priority and a running busy count
// ports: clk, rst (async, active-low), we/wa writeback, iss_valid/iss_addr issue, flush,
//        busy (per-register vector), busy_cnt (registered count), any_busy
module regfile_sb_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_cnt,
  output logic             any_busy
);
  localparam int CW = AW + 1;
  logic [NREGS-1:0] busy_d, busy_q;
  logic [AW:0] busy_cnt_d, busy_cnt_q;
  logic iss_ok, inc, dec;
  // the count moves by at most one per cycle: an issue to an idle register adds,
  // a writeback to a busy register subtracts unless the same register is re-issued
  always_comb begin
    iss_ok = iss_valid && !(ZERO_REG != 0 && is_zero_reg(32'(iss_addr)));
    inc = iss_ok && !busy_q[iss_addr];
    dec = we && busy_q[wa] && !(iss_ok && iss_addr == wa);
    busy_cnt_d = flush ? '0 : busy_cnt_q + CW'(inc) - CW'(dec);
    for (int r = 0; r < NREGS; r++)
      busy_d[r] = flush ? 1'b0 : (iss_ok && iss_addr == AW'(r)) ? 1'b1 : (we && wa == AW'(r)) ? 1'b0 : busy_q[r];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end
  assign busy = busy_q;
  assign busy_cnt = busy_cnt_q;
  assign any_busy = busy_cnt_q != '0;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with write-through bypass and pending-writeback scoreboard
// ports: clk, rst (async, active-low), rd_addr/rd_data/rd_busy (NRD packed read ports),
//        we/wa/wd writeback, iss_valid/iss_addr issue, flush, busy_cnt, any_busy
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = NRD_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   wd,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic [AW:0]       busy_cnt,
  output logic              any_busy
);
  logic [XLEN-1:0] mem_d [NREGS];
  logic [XLEN-1:0] mem_q [NREGS];
  logic [NREGS-1:0] busy;
  logic wr_ok;
  always_comb begin
    wr_ok = we && !(ZERO_REG != 0 && is_zero_reg(32'(wa)));
    mem_d = mem_q;
    if (wr_ok) mem_d[wa] = wd;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  regfile_sb_scoreboard #(.NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .rst(rst),
    .we(we),
    .wa(wa),
    .iss_valid(iss_valid),
    .iss_addr(iss_addr),
    .flush(flush),
    .busy(busy),
    .busy_cnt(busy_cnt),
    .any_busy(any_busy)
  );
  // a write to the zero register only matches a read of the zero register, which is forced to 0,
  // so the raw address match is enough for both the bypass and the hazard mask
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic zero, hit;
    assign a = rd_addr[k*AW +: AW];
    assign zero = ZERO_REG != 0 && is_zero_reg(32'(a));
    assign hit = we && wa == a;
    assign rd_data[k*XLEN +: XLEN] = (!rst || zero) ? '0 : hit ? wd : mem_q[a];
    assign rd_busy[k] = rst && !zero && busy[a] && !hit;
  end
endmodule
